// File: rtl/sampling_layer1_pool_pkg.sv
// Shared constants, pixel type and signed max helper for the layer-1 pooling stage.
package sampling_layer1_pool_pkg;
  localparam int DATA_W = 16;
  localparam int IMG_W  = 24;
  localparam int IMG_H  = 24;
  localparam int POOL_W = IMG_W / 2;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  // IMG_W is even, so col/2 always fits one bit narrower than col
  localparam int IDX_W  = COL_W - 1;

  typedef logic signed [DATA_W-1:0] pix_t;

  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sampling_line_buffer.sv
// Holds the horizontal pair maxima of the last even row, one slot per pooled column.
module sampling_line_buffer
  import sampling_layer1_pool_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  pix_t             wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output pix_t             rd_data
);
  pix_t mem [POOL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POOL_W; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/sampling_layer1_pool.sv
// 2x2 stride-2 signed max pooling over a raster-ordered IMG_W x IMG_H feature map.
module sampling_layer1_pool
  import sampling_layer1_pool_pkg::*;
(
  input  logic              Clock,
  input  logic              Input_Reset,
  input  logic [DATA_W-1:0] Input_Pixel,
  input  logic              Input_Valid,
  input  logic              Input_Finish,
  output logic [DATA_W-1:0] Output_Pixel,
  output logic              Output_Valid,
  output logic              Output_Finish,
  output logic [15:0]       Watch
);
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  pix_t             h, pix, pair, lb_rd, pooled;
  logic             accept, col_last, row_last, lb_we, emit;

  // Finish wins over a coincident valid pixel, which is dropped
  assign accept   = Input_Valid && !Input_Finish;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign pix      = pix_t'(Input_Pixel);
  assign pair     = smax(h, pix);
  assign pooled   = smax(lb_rd, pair);
  assign lb_we    = accept && !row[0] && col[0];
  assign emit     = accept && row[0] && col[0];

  sampling_line_buffer u_lb (
    .clk     (Clock),
    .rst_n   (Input_Reset),
    .wr_en   (lb_we),
    .wr_idx  (col[COL_W-1:1]),
    .wr_data (pair),
    .rd_idx  (col[COL_W-1:1]),
    .rd_data (lb_rd)
  );

  always_ff @(posedge Clock or negedge Input_Reset) begin
    if (!Input_Reset) begin
      col <= '0;
      row <= '0;
    end else if (Input_Finish) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Input_Reset) begin
    if (!Input_Reset) begin
      h <= '0;
    end else if (accept && !col[0]) begin
      h <= pix;
    end
  end

  always_ff @(posedge Clock or negedge Input_Reset) begin
    if (!Input_Reset) begin
      Output_Pixel  <= '0;
      Output_Valid  <= 1'b0;
      Output_Finish <= 1'b0;
    end else begin
      Output_Valid  <= emit;
      Output_Finish <= Input_Finish || (accept && row_last && col_last);
      if (emit) Output_Pixel <= pooled;
    end
  end

  assign Watch = {{(8-ROW_W){1'b0}}, row, {(8-COL_W){1'b0}}, col};
endmodule

// File: tb/tb_sampling_layer1_pool.sv
// Directed bench for the 2x2 max-pooling stage: ramps, bubbles, signed windows, reset, abort.
module tb_sampling_layer1_pool;
  logic        Clock = 1'b0;
  logic        Input_Reset;
  logic [15:0] Input_Pixel;
  logic        Input_Valid;
  logic        Input_Finish;
  logic [15:0] Output_Pixel;
  logic        Output_Valid;
  logic        Output_Finish;
  logic [15:0] Watch;

  int n_run = 0;
  int n_fail = 0;

  logic [15:0] outs[$];
  int          n_fin = 0;
  int          fin_at = -1;
  logic        fin_vld = 1'b0;
  logic [15:0] fin_pix = '0;

  sampling_layer1_pool dut (
    .Clock         (Clock),
    .Input_Reset   (Input_Reset),
    .Input_Pixel   (Input_Pixel),
    .Input_Valid   (Input_Valid),
    .Input_Finish  (Input_Finish),
    .Output_Pixel  (Output_Pixel),
    .Output_Valid  (Output_Valid),
    .Output_Finish (Output_Finish),
    .Watch         (Watch)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (Output_Valid === 1'b1) outs.push_back(Output_Pixel);
    if (Output_Finish === 1'b1) begin
      n_fin++;
      fin_at  = outs.size();
      fin_vld = Output_Valid;
      fin_pix = Output_Pixel;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ramp pixel value at input index i is i, so window (r,c) max is its bottom-right pixel
  function automatic logic [15:0] exp_ramp(input int k);
    return 16'(48 * (k / 12) + 2 * (k % 12) + 25);
  endfunction

  task automatic send(input logic [15:0] p, input bit bubbles);
    if (bubbles) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge Clock);
        Input_Valid = 1'b0;
      end
    end
    @(negedge Clock);
    Input_Valid = 1'b1;
    Input_Pixel = p;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clock);
      Input_Valid  = 1'b0;
      Input_Finish = 1'b0;
    end
  endtask

  task automatic clear_mon();
    outs.delete();
    n_fin   = 0;
    fin_at  = -1;
    fin_vld = 1'b0;
  endtask

  task automatic ramp(input bit bubbles);
    for (int i = 0; i < 576; i++) send(16'(i), bubbles);
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_count"}, outs.size(), 144);
    for (int k = 0; k < 144 && k < outs.size(); k++)
      check($sformatf("%s_px%0d", tag, k), outs[k], exp_ramp(k));
    check({tag, "_fin_n"}, n_fin, 1);
    check({tag, "_fin_at"}, fin_at, 144);
    check({tag, "_fin_vld"}, fin_vld, 1);
    check({tag, "_fin_px"}, fin_pix, 16'd575);
  endtask

  logic [15:0] img [576];

  initial begin
    Input_Reset  = 1'b0;
    Input_Pixel  = '0;
    Input_Valid  = 1'b0;
    Input_Finish = 1'b0;
    #2;
    check("rst_pix", Output_Pixel, 0);
    check("rst_vld", Output_Valid, 0);
    check("rst_fin", Output_Finish, 0);
    check("rst_watch", Watch, 0);
    idle(2);
    Input_Reset = 1'b1;
    idle(1);

    // Continuous ramp
    clear_mon();
    ramp(1'b0);
    idle(3);
    check_ramp("ramp");
    check("ramp_watch", Watch, 0);

    // Ramp with random bubbles
    clear_mon();
    ramp(1'b1);
    idle(3);
    check_ramp("bub");

    // Signed windows in the first three pooled positions, ramp elsewhere
    for (int i = 0; i < 576; i++) img[i] = 16'(i);
    img[0]  = 16'hFFFB; img[1]  = 16'hFFFD; img[24] = 16'hFFF9; img[25] = 16'hFFF7;
    img[2]  = 16'h8000; img[3]  = 16'h8000; img[26] = 16'h8000; img[27] = 16'h8000;
    img[4]  = 16'h7FFF; img[5]  = 16'h8000; img[28] = 16'h8000; img[29] = 16'h8000;
    clear_mon();
    for (int i = 0; i < 576; i++) send(img[i], 1'b0);
    idle(3);
    check("sgn_count", outs.size(), 144);
    if (outs.size() >= 4) begin
      check("sgn_neg", outs[0], 16'hFFFD);
      check("sgn_min", outs[1], 16'h8000);
      check("sgn_max", outs[2], 16'h7FFF);
      check("sgn_next", outs[3], exp_ramp(3));
    end

    // Two frames back to back without reset
    clear_mon();
    ramp(1'b0);
    ramp(1'b0);
    idle(3);
    check("b2b_count", outs.size(), 288);
    for (int k = 0; k < 288 && k < outs.size(); k++)
      check($sformatf("b2b_px%0d", k), outs[k], exp_ramp(k % 144));
    check("b2b_fin_n", n_fin, 2);
    check("b2b_fin_at", fin_at, 288);

    // Reset mid-frame, then a fresh ramp
    for (int i = 0; i < 300; i++) send(16'hFFFF - 16'(i), 1'b0);
    @(negedge Clock);
    Input_Valid = 1'b0;
    Input_Reset = 1'b0;
    @(negedge Clock);
    check("mrst_watch", Watch, 0);
    check("mrst_vld", Output_Valid, 0);
    check("mrst_pix", Output_Pixel, 0);
    Input_Reset = 1'b1;
    idle(1);
    clear_mon();
    ramp(1'b0);
    idle(3);
    check_ramp("mrst");

    // Abort after 100 pixels; a pixel presented with finish is dropped
    clear_mon();
    for (int i = 0; i < 100; i++) send(16'(i), 1'b0);
    @(negedge Clock);
    check("abort_watch_pre", Watch, 16'h0404);
    Input_Valid  = 1'b1;
    Input_Pixel  = 16'h7FFF;
    Input_Finish = 1'b1;
    @(negedge Clock);
    Input_Valid  = 1'b0;
    Input_Finish = 1'b0;
    check("abort_fin", Output_Finish, 1);
    check("abort_vld", Output_Valid, 0);
    check("abort_watch", Watch, 0);
    check("abort_outs", outs.size(), 24);
    idle(2);
    check("abort_fin_once", Output_Finish, 0);
    clear_mon();
    ramp(1'b1);
    idle(3);
    check_ramp("post");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
